// File: rtl/window_generator_pkg.sv
// Shared defaults, width helpers and the window index map for the KxK window generator.
// idx() fixes the packing order of out_window and is shared by design and bench.
package window_generator_pkg;

  localparam int BITS_D        = 9;
  localparam int KERNEL_SIZE_D = 3;
  localparam int IMG_WIDTH_D   = 16;
  localparam int IMG_HEIGHT_D  = 16;
  localparam int STRIDE_D      = 1;

  function automatic int clog2_min1(input int n);
    return ($clog2(n) < 1) ? 1 : $clog2(n);
  endfunction

  localparam int ROW_W = clog2_min1(IMG_HEIGHT_D);
  localparam int COL_W = clog2_min1(IMG_WIDTH_D);
  localparam int WIN_W = KERNEL_SIZE_D * KERNEL_SIZE_D * BITS_D;

  function automatic int idx(input int i, input int j, input int k = KERNEL_SIZE_D);
    return i * k + j;
  endfunction

endpackage

// File: rtl/window_generator_if.sv
// Pixel-in / window-out stream bundle; slave is the generator's view, master the producer/consumer's.
interface window_generator_if
  import window_generator_pkg::*;
#(
  parameter int BITS        = BITS_D,
  parameter int KERNEL_SIZE = KERNEL_SIZE_D,
  parameter int IMG_WIDTH   = IMG_WIDTH_D,
  parameter int IMG_HEIGHT  = IMG_HEIGHT_D
) ();

  localparam int IF_ROW_W = clog2_min1(IMG_HEIGHT);
  localparam int IF_COL_W = clog2_min1(IMG_WIDTH);
  localparam int IF_WIN_W = KERNEL_SIZE * KERNEL_SIZE * BITS;

  logic                in_valid;
  logic                in_ready;
  logic [BITS-1:0]     in_pixel;
  logic                out_valid;
  logic                out_ready;
  logic [IF_WIN_W-1:0] out_window;
  logic [IF_ROW_W-1:0] out_row;
  logic [IF_COL_W-1:0] out_col;
  logic                frame_done;

  modport slave (
    input  in_valid, in_pixel, out_ready,
    output in_ready, out_valid, out_window, out_row, out_col, frame_done
  );

  modport master (
    output in_valid, in_pixel, out_ready,
    input  in_ready, out_valid, out_window, out_row, out_col, frame_done
  );

endinterface

// File: rtl/window_generator_line_buffer_row.sv
// One-row pixel delay: circular RAM, o_pixel is the pixel written DEPTH enables ago; 0-cycle read.
// Advances only on i_en; data storage is never cleared, only the pointer resets.
module line_buffer_row
  import window_generator_pkg::*;
#(
  parameter int BITS  = BITS_D,
  parameter int DEPTH = IMG_WIDTH_D
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_en,
  input  logic [BITS-1:0] i_pixel,
  output logic [BITS-1:0] o_pixel
);

  localparam int PTR_W = clog2_min1(DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  logic [BITS-1:0]  r_mem [DEPTH];
  logic [PTR_W-1:0] r_ptr;

  // Read-before-write at the same slot yields exactly a DEPTH-deep delay.
  assign o_pixel = r_mem[r_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr <= '0;
    end else if (i_en) begin
      r_ptr <= (r_ptr == PTR_LAST) ? '0 : r_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (i_en) begin
      r_mem[r_ptr] <= i_pixel;
    end
  end

endmodule

// File: rtl/window_generator.sv
// KxK sliding-window generator: one pixel per accept, window out one cycle after the completing accept.
// Input stalls only while a window is held unaccepted; a consumed window can be replaced in the same cycle.
module window_generator
  import window_generator_pkg::*;
#(
  parameter int BITS        = BITS_D,
  parameter int KERNEL_SIZE = KERNEL_SIZE_D,
  parameter int IMG_WIDTH   = IMG_WIDTH_D,
  parameter int IMG_HEIGHT  = IMG_HEIGHT_D,
  parameter int STRIDE      = STRIDE_D
) (
  input  logic               clk,
  input  logic               reset,
  window_generator_if.slave  io_win
);

  localparam int K      = KERNEL_SIZE;
  localparam int R_W    = clog2_min1(IMG_HEIGHT);
  localparam int C_W    = clog2_min1(IMG_WIDTH);
  localparam int PH_W   = clog2_min1(STRIDE);
  localparam int W_W    = K * K * BITS;

  localparam logic [R_W-1:0]  ROW_KM1  = R_W'(K - 1);
  localparam logic [R_W-1:0]  ROW_LAST = R_W'(IMG_HEIGHT - 1);
  localparam logic [R_W-1:0]  ROW_ONE  = R_W'(1);
  localparam logic [C_W-1:0]  COL_KM1  = C_W'(K - 1);
  localparam logic [C_W-1:0]  COL_LAST = C_W'(IMG_WIDTH - 1);
  localparam logic [C_W-1:0]  COL_ONE  = C_W'(1);
  localparam logic [PH_W-1:0] PH_LAST  = PH_W'(STRIDE - 1);
  localparam logic [PH_W-1:0] PH_ONE   = PH_W'(1);

  generate
    if (K < 1 || K > IMG_WIDTH || K > IMG_HEIGHT || STRIDE < 1) begin : g_bad_params
      $error("window_generator: need 1 <= KERNEL_SIZE <= IMG_WIDTH/IMG_HEIGHT and STRIDE >= 1");
    end
  endgenerate

  logic [R_W-1:0]  r_row;
  logic [C_W-1:0]  r_col;
  logic [PH_W-1:0] r_rph;
  logic [PH_W-1:0] r_cph;
  logic [BITS-1:0] r_win [K][K];
  logic            r_out_valid;
  logic [W_W-1:0]  r_out_window;
  logic [R_W-1:0]  r_out_row;
  logic [C_W-1:0]  r_out_col;
  logic            r_frame_done;

  logic            w_acc;
  logic            w_emit;
  logic            w_last_col;
  logic            w_last_row;
  logic [BITS-1:0] w_lb_out [K];
  logic [BITS-1:0] w_next_win [K][K];
  logic [W_W-1:0]  w_next_flat;

  assign io_win.in_ready   = !(r_out_valid && !io_win.out_ready);
  assign io_win.out_valid  = r_out_valid;
  assign io_win.out_window = r_out_window;
  assign io_win.out_row    = r_out_row;
  assign io_win.out_col    = r_out_col;
  assign io_win.frame_done = r_frame_done;

  assign w_acc      = io_win.in_valid && io_win.in_ready;
  assign w_last_col = (r_col == COL_LAST);
  assign w_last_row = (r_row == ROW_LAST);
  assign w_emit     = w_acc && (r_row >= ROW_KM1) && (r_col >= COL_KM1) &&
                      (r_rph == '0) && (r_cph == '0);

  // w_lb_out[k] is the pixel accepted k rows ago in the same column; k = 0 is the live pixel.
  assign w_lb_out[0] = io_win.in_pixel;

  generate
    for (genvar k = 1; k < K; k++) begin : g_lb
      line_buffer_row #(
        .BITS  (BITS),
        .DEPTH (IMG_WIDTH)
      ) u_line_buffer_row (
        .clk     (clk),
        .reset   (reset),
        .i_en    (w_acc),
        .i_pixel (w_lb_out[k-1]),
        .o_pixel (w_lb_out[k])
      );
    end
  endgenerate

  always_comb begin
    for (int i = 0; i < K; i++) begin
      for (int j = 0; j < K - 1; j++) begin
        w_next_win[i][j] = r_win[i][j+1];
      end
      w_next_win[i][K-1] = w_lb_out[K-1-i];
    end
  end

  always_comb begin
    w_next_flat = '0;
    for (int i = 0; i < K; i++) begin
      for (int j = 0; j < K; j++) begin
        w_next_flat[BITS*idx(i, j, K) +: BITS] = w_next_win[i][j];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_acc) begin
      r_win <= w_next_win;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_row        <= '0;
      r_col        <= '0;
      r_rph        <= '0;
      r_cph        <= '0;
      r_out_valid  <= 1'b0;
      r_out_window <= '0;
      r_out_row    <= '0;
      r_out_col    <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_acc && w_last_col && w_last_row;

      // Stride phases stay at 0 until the first in-bounds position on each axis.
      if (w_acc) begin
        if (w_last_col) begin
          r_col <= '0;
          r_cph <= '0;
          if (w_last_row) begin
            r_row <= '0;
            r_rph <= '0;
          end else begin
            r_row <= r_row + ROW_ONE;
            if (r_row >= ROW_KM1) begin
              r_rph <= (r_rph == PH_LAST) ? '0 : r_rph + PH_ONE;
            end
          end
        end else begin
          r_col <= r_col + COL_ONE;
          if (r_col >= COL_KM1) begin
            r_cph <= (r_cph == PH_LAST) ? '0 : r_cph + PH_ONE;
          end
        end
      end

      if (w_emit) begin
        r_out_valid  <= 1'b1;
        r_out_window <= w_next_flat;
        r_out_row    <= r_row - ROW_KM1;
        r_out_col    <= r_col - COL_KM1;
      end else if (io_win.out_ready) begin
        r_out_valid  <= 1'b0;
      end
    end
  end

endmodule
